// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/MEM requester handshakes and memory command bus for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          if_req;
  logic [AW-1:0] if_line;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_line;
  logic [DW-1:0] mem_wdata;

  logic          if_gnt;
  logic          mem_gnt;
  logic          if_valid;
  logic          mem_valid;
  logic [DW-1:0] if_rdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;

  logic          ram_en;
  logic          ram_wr;
  logic [AW-1:0] ram_line;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  // Arbiter side: takes requests and read data, drives grants, responses and memory commands.
  modport slave (
    input  if_req, if_line, mem_req, mem_we, mem_line, mem_wdata, ram_dout,
    output if_gnt, mem_gnt, if_valid, mem_valid, if_rdata, mem_rdata,
    output stall_if, stall_mem, ram_en, ram_wr, ram_line, ram_din
  );

  modport master (
    output if_req, if_line, mem_req, mem_we, mem_line, mem_wdata, ram_dout,
    input  if_gnt, mem_gnt, if_valid, mem_valid, if_rdata, mem_rdata,
    input  stall_if, stall_mem, ram_en, ram_wr, ram_line, ram_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and MEM stage
// with MEM priority, a fetch starvation limit and registered read-data returns.
module mem_port_arbiter #(
  parameter int DW           = 16,
  parameter int AW           = 4,
  parameter int STARVE_LIMIT = 2
) (
  input logic              clkwire,
  input logic              rstwire_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_MEM, RET} state_t;

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  state_t        state;
  logic [1:0]    streak;
  logic          if_valid_q;
  logic          mem_valid_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] mem_rdata_q;

  logic          arb;
  logic          if_win;
  logic          mem_win;

  // Grants are combinational and masked while reset is held so no command leaks out.
  always_comb begin
    arb     = rstwire_n && (state == IDLE || state == RET);
    if_win  = arb && bus.if_req && (!bus.mem_req || streak == LIMIT);
    mem_win = arb && bus.mem_req && !if_win;
  end

  assign bus.if_gnt    = if_win;
  assign bus.mem_gnt   = mem_win;
  assign bus.stall_if  = bus.if_req && !if_win;
  assign bus.stall_mem = bus.mem_req && !mem_win;

  assign bus.ram_en    = if_win || mem_win;
  assign bus.ram_wr    = mem_win && bus.mem_we;
  assign bus.ram_line  = if_win ? bus.if_line : (mem_win ? bus.mem_line : '0);
  assign bus.ram_din   = (mem_win && bus.mem_we) ? bus.mem_wdata : '0;

  assign bus.if_valid  = if_valid_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  always_ff @(posedge clkwire or negedge rstwire_n) begin
    if (!rstwire_n) begin
      state       <= IDLE;
      streak      <= 2'd0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;

      // Streak counts only MEM grants that made a waiting fetch lose.
      if (!bus.if_req || if_win)
        streak <= 2'd0;
      else if (mem_win && streak != LIMIT)
        streak <= streak + 2'd1;

      case (state)
        IDLE, RET: begin
          if (if_win)
            state <= RD_IF;
          else if (mem_win && !bus.mem_we)
            state <= RD_MEM;
          else
            state <= IDLE;
        end
        RD_IF: begin
          if_rdata_q <= bus.ram_dout;
          if_valid_q <= 1'b1;
          state      <= RET;
        end
        RD_MEM: begin
          mem_rdata_q <= bus.ram_dout;
          mem_valid_q <= 1'b1;
          state       <= RET;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter against a 16x16 memory model
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [15:0] mem [16];

  mem_port_arbiter_if #(.DW(16), .AW(4)) bus ();

  mem_port_arbiter #(.DW(16), .AW(4), .STARVE_LIMIT(2)) dut (
    .clkwire   (clk),
    .rstwire_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, one-cycle read latency; contents seeded while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
      mem[9] <= 16'h1234;
    end else if (bus.ram_en) begin
      if (bus.ram_wr) mem[bus.ram_line] <= bus.ram_din;
      else            bus.ram_dout <= mem[bus.ram_line];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.if_req = 1'b1; bus.if_line = 4'd0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_line = 4'd0; bus.mem_wdata = 16'd0;
    bus.ram_dout = 16'd0;

    // Reset state with a fetch request pending
    tick(); look();
    check_eq("rst_if_gnt", bus.if_gnt, 0);
    check_eq("rst_stall_if", bus.stall_if, 1);
    check_eq("rst_ram_en", bus.ram_en, 0);
    check_eq("rst_ram_line", bus.ram_line, 0);
    check_eq("rst_if_valid", bus.if_valid, 0);
    check_eq("rst_if_rdata", bus.if_rdata, 0);
    check_eq("rst_mem_rdata", bus.mem_rdata, 0);
    check_eq("rst_streak", dut.streak, 0);
    tick();
    rst_n = 1'b1; bus.if_req = 1'b0;
    tick();

    // Single fetch of line 9
    bus.if_req = 1'b1; bus.if_line = 4'd9;
    look();
    check_eq("f_if_gnt", bus.if_gnt, 1);
    check_eq("f_ram_en", bus.ram_en, 1);
    check_eq("f_ram_line", bus.ram_line, 9);
    check_eq("f_ram_wr", bus.ram_wr, 0);
    tick(); bus.if_req = 1'b0;
    look();
    check_eq("f_c1_ram_en", bus.ram_en, 0);
    check_eq("f_c1_if_valid", bus.if_valid, 0);
    tick(); look();
    check_eq("f_c2_if_valid", bus.if_valid, 1);
    check_eq("f_c2_if_rdata", bus.if_rdata, 16'h1234);
    check_eq("f_c2_mem_valid", bus.mem_valid, 0);
    tick(); look();
    check_eq("f_c3_if_valid", bus.if_valid, 0);
    check_eq("f_c3_if_rdata", bus.if_rdata, 16'h1234);

    // Store 0x0004 to line 6, then load it back
    tick();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_line = 4'd6; bus.mem_wdata = 16'h0004;
    look();
    check_eq("sl_c0_mem_gnt", bus.mem_gnt, 1);
    check_eq("sl_c0_ram_wr", bus.ram_wr, 1);
    check_eq("sl_c0_ram_din", bus.ram_din, 16'h0004);
    check_eq("sl_c0_ram_line", bus.ram_line, 6);
    tick(); bus.mem_we = 1'b0;
    look();
    check_eq("sl_c1_mem_gnt", bus.mem_gnt, 1);
    check_eq("sl_c1_ram_wr", bus.ram_wr, 0);
    check_eq("sl_c1_mem_valid", bus.mem_valid, 0);
    tick(); bus.mem_req = 1'b0;
    look();
    check_eq("sl_c2_ram_en", bus.ram_en, 0);
    check_eq("sl_c2_mem_valid", bus.mem_valid, 0);
    tick(); look();
    check_eq("sl_c3_mem_valid", bus.mem_valid, 1);
    check_eq("sl_c3_mem_rdata", bus.mem_rdata, 16'h0004);
    check_eq("sl_c3_if_valid", bus.if_valid, 0);

    // Simultaneous fetch (line 9) and load (line 3)
    tick();
    bus.if_req = 1'b1; bus.if_line = 4'd9;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_line = 4'd3;
    look();
    check_eq("sim_c0_mem_gnt", bus.mem_gnt, 1);
    check_eq("sim_c0_if_gnt", bus.if_gnt, 0);
    check_eq("sim_c0_stall_if", bus.stall_if, 1);
    check_eq("sim_c0_stall_mem", bus.stall_mem, 0);
    tick(); bus.mem_req = 1'b0;
    look();
    check_eq("sim_c1_stall_if", bus.stall_if, 1);
    check_eq("sim_c1_if_gnt", bus.if_gnt, 0);
    check_eq("sim_c1_ram_en", bus.ram_en, 0);
    tick(); look();
    check_eq("sim_c2_mem_valid", bus.mem_valid, 1);
    check_eq("sim_c2_mem_rdata", bus.mem_rdata, 16'hA003);
    check_eq("sim_c2_if_gnt", bus.if_gnt, 1);
    check_eq("sim_c2_stall_if", bus.stall_if, 0);
    check_eq("sim_c2_ram_line", bus.ram_line, 9);
    tick(); bus.if_req = 1'b0;
    tick(); look();
    check_eq("sim_c4_if_valid", bus.if_valid, 1);
    check_eq("sim_c4_if_rdata", bus.if_rdata, 16'h1234);

    // Starvation limit: fetch held, stores back to back
    tick();
    bus.if_req = 1'b1; bus.if_line = 4'd9;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_line = 4'd12; bus.mem_wdata = 16'h0BEE;
    for (int c = 0; c < 6; c++) begin
      logic [5:0] exp_mem;
      logic [5:0] exp_if;
      exp_mem = 6'b110011;
      exp_if  = 6'b000100;
      look();
      check_eq($sformatf("stv_c%0d_mem_gnt", c), bus.mem_gnt, exp_mem[c]);
      check_eq($sformatf("stv_c%0d_if_gnt", c), bus.if_gnt, exp_if[c]);
      if (c == 2) check_eq("stv_c2_streak", dut.streak, 2);
      if (c == 4) check_eq("stv_c4_if_valid", bus.if_valid, 1);
      tick();
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    tick(); look();
    check_eq("stv_streak_clear", dut.streak, 0);
    check_eq("stv_mem12", mem[12], 16'h0BEE);

    // Reset pulse during the read cycle of a fetch
    tick();
    bus.if_req = 1'b1; bus.if_line = 4'd9;
    look();
    check_eq("rr_c0_if_gnt", bus.if_gnt, 1);
    tick(); bus.if_req = 1'b0;
    rst_n = 1'b0;
    look();
    check_eq("rr_c1_ram_en", bus.ram_en, 0);
    check_eq("rr_c1_if_rdata", bus.if_rdata, 0);
    check_eq("rr_c1_mem_rdata", bus.mem_rdata, 0);
    check_eq("rr_c1_if_valid", bus.if_valid, 0);
    #2 rst_n = 1'b1;
    tick(); look();
    check_eq("rr_c2_if_valid", bus.if_valid, 0);
    tick(); look();
    check_eq("rr_c3_if_valid", bus.if_valid, 0);
    tick();
    bus.if_req = 1'b1; bus.if_line = 4'd3;
    look();
    check_eq("rr_new_if_gnt", bus.if_gnt, 1);
    tick(); bus.if_req = 1'b0;
    tick(); look();
    check_eq("rr_new_if_valid", bus.if_valid, 1);
    check_eq("rr_new_if_rdata", bus.if_rdata, 16'hA003);

    // Idle: no requests for 10 cycles
    for (int c = 0; c < 10; c++) begin
      tick(); look();
      check_eq($sformatf("idle_c%0d_ram_en", c), bus.ram_en, 0);
      check_eq($sformatf("idle_c%0d_streak", c), dut.streak, 0);
      check_eq($sformatf("idle_c%0d_if_rdata", c), bus.if_rdata, 16'hA003);
      check_eq($sformatf("idle_c%0d_mem_rdata", c), bus.mem_rdata, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
